// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
// Produces PC enable/redirect and the enable/flush pair of every pipeline
// latch. Handles memory-wait freezes, load-use bubbles (LU_BUBBLES deep),
// taken-branch/jump squashes, a sticky halt and a saturating stall counter.
// Control outputs are combinational from the registered state and the
// current inputs. They are forced low while nRST is asserted.
module hazard_ctrl_unit #(
   parameter int REG_W       = 5,
   parameter int LU_BUBBLES  = 1,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   ihit,
   input  logic                   dhit,
   input  logic                   mem_dREN,
   input  logic                   mem_dWEN,
   input  logic [REG_W-1:0]       id_rs,
   input  logic [REG_W-1:0]       id_rt,
   input  logic                   ex_memtoreg,
   input  logic [REG_W-1:0]       ex_wsel,
   input  logic                   ex_branch_taken,
   input  logic                   id_jump,
   input  logic                   wb_halt,
   output logic                   enable_pc,
   output logic                   pc_redirect,
   output logic                   enable_IF_ID,
   output logic                   enable_ID_EX,
   output logic                   enable_EX_MEM,
   output logic                   enable_MEM_WB,
   output logic                   flush_IF_ID,
   output logic                   flush_ID_EX,
   output logic                   flush_EX_MEM,
   output logic                   flush_MEM_WB,
   output logic                   halted,
   output logic [STALL_CNT_W-1:0] stall_count
);

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_LU_STALL = 2'd1,
      ST_HALT     = 2'd2
   } state_t;

   // Bubble counter preload: remaining bubbles after the first one.
   localparam logic [1:0] LU_LOAD = 2'(LU_BUBBLES - 1);

   // Control bundle layout:
   // {enable_pc, pc_redirect, en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB,
   //  fl_IF_ID, fl_ID_EX, fl_EX_MEM, fl_MEM_WB}
   localparam logic [9:0] CTL_FREEZE = 10'b00_0000_0000;
   localparam logic [9:0] CTL_NORMAL = 10'b10_1111_0000;
   localparam logic [9:0] CTL_BRANCH = 10'b11_1111_1100;
   localparam logic [9:0] CTL_JUMP   = 10'b11_1111_1000;
   localparam logic [9:0] CTL_BUBBLE = 10'b00_0111_0100;
   localparam logic [9:0] CTL_RETIRE = 10'b00_0011_0010;

   // Load in EX whose destination feeds an ID-stage source ($0 never hazards).
   function automatic logic f_lu_hazard(
      input logic             memtoreg,
      input logic [REG_W-1:0] wsel,
      input logic [REG_W-1:0] rs,
      input logic [REG_W-1:0] rt
   );
      return memtoreg & (wsel != {REG_W{1'b0}}) & ((wsel == rs) | (wsel == rt));
   endfunction

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [STALL_CNT_W-1:0] f_sat_inc(
      input logic [STALL_CNT_W-1:0] v
   );
      return (&v) ? v : (v + {{(STALL_CNT_W-1){1'b0}}, 1'b1});
   endfunction

   state_t                 r_state;
   logic [1:0]             r_bub;
   logic                   r_halted;
   logic [STALL_CNT_W-1:0] r_stall_cnt;

   logic                   w_dreq;
   logic                   w_advance;
   logic                   w_retire;
   logic                   w_lu_hazard;
   logic [9:0]             w_ctl;
   state_t                 w_state_fsm;
   state_t                 w_next_state;
   logic [1:0]             w_bub_next;
   logic                   w_stall_inc;

   assign w_dreq      = mem_dREN | mem_dWEN;
   assign w_advance   = ihit & (~w_dreq | dhit);
   // Data access finished while fetch is still pending: retire it only.
   assign w_retire    = w_dreq & dhit & ~ihit;
   assign w_lu_hazard = f_lu_hazard(ex_memtoreg, ex_wsel, id_rs, id_rt);

   // Control decode and next-state selection for RUN / LU_STALL / HALT.
   always_comb begin
      w_ctl       = CTL_FREEZE;
      w_state_fsm = r_state;
      w_bub_next  = r_bub;
      case (r_state)
         ST_RUN: begin
            if (w_advance) begin
               if (ex_branch_taken) begin
                  w_ctl = CTL_BRANCH;
               end else if (w_lu_hazard) begin
                  w_ctl       = CTL_BUBBLE;
                  w_bub_next  = LU_LOAD;
                  w_state_fsm = (LU_LOAD != 2'd0) ? ST_LU_STALL : ST_RUN;
               end else if (id_jump) begin
                  w_ctl = CTL_JUMP;
               end else begin
                  w_ctl = CTL_NORMAL;
               end
            end else if (w_retire) begin
               w_ctl = CTL_RETIRE;
            end else begin
               w_ctl = CTL_FREEZE;
            end
         end
         ST_LU_STALL: begin
            if (w_advance) begin
               if (ex_branch_taken) begin
                  w_ctl       = CTL_BRANCH;
                  w_bub_next  = 2'd0;
                  w_state_fsm = ST_RUN;
               end else begin
                  w_ctl       = CTL_BUBBLE;
                  w_bub_next  = r_bub - 2'd1;
                  w_state_fsm = (r_bub == 2'd1) ? ST_RUN : ST_LU_STALL;
               end
            end else if (w_retire) begin
               w_ctl = CTL_RETIRE;
            end else begin
               w_ctl = CTL_FREEZE;
            end
         end
         ST_HALT: begin
            w_ctl = CTL_FREEZE;
         end
         default: begin
            w_ctl       = CTL_FREEZE;
            w_state_fsm = ST_RUN;
            w_bub_next  = 2'd0;
         end
      endcase
   end

   // A halt reaching WB wins over every other transition.
   assign w_next_state = wb_halt ? ST_HALT : w_state_fsm;
   assign w_stall_inc  = ~w_ctl[9] & ~r_halted;

   // State, bubble counter, sticky halt and stall counter registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state     <= ST_RUN;
         r_bub       <= 2'd0;
         r_halted    <= 1'b0;
         r_stall_cnt <= {STALL_CNT_W{1'b0}};
      end else begin
         r_state  <= w_next_state;
         r_bub    <= w_bub_next;
         r_halted <= r_halted | wb_halt;
         if (w_stall_inc) begin
            r_stall_cnt <= f_sat_inc(r_stall_cnt);
         end else begin
            r_stall_cnt <= r_stall_cnt;
         end
      end
   end

   assign enable_pc     = nRST & w_ctl[9];
   assign pc_redirect   = nRST & w_ctl[8];
   assign enable_IF_ID  = nRST & w_ctl[7];
   assign enable_ID_EX  = nRST & w_ctl[6];
   assign enable_EX_MEM = nRST & w_ctl[5];
   assign enable_MEM_WB = nRST & w_ctl[4];
   assign flush_IF_ID   = nRST & w_ctl[3];
   assign flush_ID_EX   = nRST & w_ctl[2];
   assign flush_EX_MEM  = nRST & w_ctl[1];
   assign flush_MEM_WB  = nRST & w_ctl[0];
   assign halted        = r_halted;
   assign stall_count   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: two instances (LU_BUBBLES=1 and =3) share the
// same stimulus; a table-driven model predicts every output each cycle.
module tb_hazard_ctrl_unit;

   logic       CLK = 1'b0;
   logic       nRST = 1'b0;
   logic       ihit, dhit, dren, dwen, m2r, br, jmp, whalt;
   logic [4:0] rs, rt, wsel;

   logic en_pc1, redir1, en_if1, en_id1, en_em1, en_mw1, fl_if1, fl_id1, fl_em1, fl_mw1, halted1;
   logic en_pc3, redir3, en_if3, en_id3, en_em3, en_mw3, fl_if3, fl_id3, fl_em3, fl_mw3, halted3;
   logic [15:0] sc1, sc3;
   logic [9:0]  c1, c3;

   assign c1 = {en_pc1, redir1, en_if1, en_id1, en_em1, en_mw1, fl_if1, fl_id1, fl_em1, fl_mw1};
   assign c3 = {en_pc3, redir3, en_if3, en_id3, en_em3, en_mw3, fl_if3, fl_id3, fl_em3, fl_mw3};

   hazard_ctrl_unit #(.REG_W(5), .LU_BUBBLES(1), .STALL_CNT_W(16)) dut1 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(dren), .mem_dWEN(dwen),
      .id_rs(rs), .id_rt(rt), .ex_memtoreg(m2r), .ex_wsel(wsel), .ex_branch_taken(br),
      .id_jump(jmp), .wb_halt(whalt), .enable_pc(en_pc1), .pc_redirect(redir1),
      .enable_IF_ID(en_if1), .enable_ID_EX(en_id1), .enable_EX_MEM(en_em1), .enable_MEM_WB(en_mw1),
      .flush_IF_ID(fl_if1), .flush_ID_EX(fl_id1), .flush_EX_MEM(fl_em1), .flush_MEM_WB(fl_mw1),
      .halted(halted1), .stall_count(sc1));

   hazard_ctrl_unit #(.REG_W(5), .LU_BUBBLES(3), .STALL_CNT_W(16)) dut3 (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .mem_dREN(dren), .mem_dWEN(dwen),
      .id_rs(rs), .id_rt(rt), .ex_memtoreg(m2r), .ex_wsel(wsel), .ex_branch_taken(br),
      .id_jump(jmp), .wb_halt(whalt), .enable_pc(en_pc3), .pc_redirect(redir3),
      .enable_IF_ID(en_if3), .enable_ID_EX(en_id3), .enable_EX_MEM(en_em3), .enable_MEM_WB(en_mw3),
      .flush_IF_ID(fl_if3), .flush_ID_EX(fl_id3), .flush_EX_MEM(fl_em3), .flush_MEM_WB(fl_mw3),
      .halted(halted3), .stall_count(sc3));

   always #5 CLK = ~CLK;

   int n_tests = 0;
   int n_fail  = 0;

   // Expected control patterns, read straight off the behaviour rules.
   localparam logic [9:0] E_FREEZE = 10'b0000000000;
   localparam logic [9:0] E_NORMAL = 10'b1011110000;
   localparam logic [9:0] E_BRANCH = 10'b1111111100;
   localparam logic [9:0] E_JUMP   = 10'b1111111000;
   localparam logic [9:0] E_BUBBLE = 10'b0001110100;
   localparam logic [9:0] E_RETIRE = 10'b0000110010;
   localparam int         CNT_MAX  = 65535;

   // Model state per instance: bubbles still owed, halted flag, stall count.
   int m_pend[2], m_cnt[2], m_pend_n[2], m_cnt_n[2];
   bit m_halt[2], m_halt_n[2];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_check(input int k, input logic [9:0] act, input logic act_h,
                              input logic [15:0] act_c);
      logic [9:0] e;
      int         np, nc, bub;
      bit         nh, adv, dreq, lu;
      bub = (k == 0) ? 1 : 3;
      np  = m_pend[k];
      nc  = m_cnt[k];
      nh  = m_halt[k];
      e   = E_FREEZE;
      if (!nRST) begin
         np = 0; nc = 0; nh = 0;
      end else begin
         dreq = dren | dwen;
         adv  = ihit && (!dreq || dhit);
         lu   = m2r && (wsel != 5'd0) && (wsel == rs || wsel == rt);
         if (m_halt[k]) e = E_FREEZE;
         else if (adv) begin
            if (br) begin e = E_BRANCH; np = 0; end
            else if (m_pend[k] > 0) begin e = E_BUBBLE; np = m_pend[k] - 1; end
            else if (lu) begin e = E_BUBBLE; np = bub - 1; end
            else if (jmp) e = E_JUMP;
            else e = E_NORMAL;
         end else if (dreq && dhit) e = E_RETIRE;
         else e = E_FREEZE;
         if (!e[9] && !m_halt[k] && nc < CNT_MAX) nc = nc + 1;
         if (whalt) nh = 1;
      end
      chk((k == 0) ? "b1_ctl" : "b3_ctl", {22'd0, act}, {22'd0, e});
      chk((k == 0) ? "b1_halted" : "b3_halted", {31'd0, act_h}, nRST ? {31'd0, m_halt[k]} : 32'd0);
      chk((k == 0) ? "b1_count" : "b3_count", {16'd0, act_c}, nRST ? m_cnt[k] : 32'd0);
      m_pend_n[k] <= np;
      m_cnt_n[k]  <= nc;
      m_halt_n[k] <= nh;
   endtask

   // Per-cycle comparison of both instances against the model.
   always @(negedge CLK) begin
      model_check(0, c1, halted1, sc1);
      model_check(1, c3, halted3, sc3);
   end

   // Model state update, cleared asynchronously like the design.
   always @(posedge CLK or negedge nRST) begin
      for (int k = 0; k < 2; k++) begin
         if (!nRST) begin
            m_pend[k] <= 0; m_cnt[k] <= 0; m_halt[k] <= 1'b0;
         end else begin
            m_pend[k] <= m_pend_n[k]; m_cnt[k] <= m_cnt_n[k]; m_halt[k] <= m_halt_n[k];
         end
      end
   end

   task automatic set_in(input logic ih, input logic dh, input logic rd, input logic wr,
                         input logic [4:0] s, input logic [4:0] t, input logic ld,
                         input logic [4:0] w, input logic b, input logic j, input logic h);
      ihit = ih; dhit = dh; dren = rd; dwen = wr; rs = s; rt = t;
      m2r = ld; wsel = w; br = b; jmp = j; whalt = h;
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      nRST = 1'b0;
      tick();
      tick();
      nRST = 1'b1;
   endtask

   initial begin
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      // Reset state, then free-running pipeline.
      do_reset();
      chk("reset_count", {16'd0, sc1}, 32'd0);
      chk("reset_halted", {31'd0, halted1}, 32'd0);
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      repeat (10) tick();
      chk("run_ctl", {22'd0, c1}, {22'd0, E_NORMAL});
      chk("run_count", {16'd0, sc1}, 32'd0);

      // Load-use hazard: one bubble on dut1, three on dut3.
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
      #2;
      chk("lu_en_pc", {31'd0, en_pc1}, 32'd0);
      chk("lu_en_if", {31'd0, en_if1}, 32'd0);
      chk("lu_fl_id", {31'd0, fl_id1}, 32'd1);
      chk("lu_en_id", {31'd0, en_id1}, 32'd1);
      tick();
      chk("lu_count1", {16'd0, sc1}, 32'd1);
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      repeat (3) tick();
      chk("lu3_count", {16'd0, sc3}, 32'd3);
      chk("lu3_back_run", {31'd0, en_pc3}, 32'd1);
      chk("lu_model_pin", m_cnt[1], 32'd3);
      // Destination $0 never interlocks.
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("lu_r0_en_pc", {31'd0, en_pc1}, 32'd1);
      tick();
      chk("lu_r0_count1", {16'd0, sc1}, 32'd1);
      chk("lu_r0_count3", {16'd0, sc3}, 32'd3);

      // Memory wait: 4 frozen cycles, then data retires without fetch.
      do_reset();
      set_in(1'b0, 1'b0, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      repeat (4) tick();
      chk("mw_frozen_count", {16'd0, sc1}, 32'd4);
      set_in(1'b0, 1'b1, 1'b1, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      #2;
      chk("mw_retire_ctl", {22'd0, c1}, {22'd0, E_RETIRE});
      chk("mw_fl_em", {31'd0, fl_em1}, 32'd1);
      tick();
      chk("mw_count", {16'd0, sc1}, 32'd5);
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      tick();
      chk("mw_store_count", {16'd0, sc1}, 32'd5);

      // Taken branch beats load-use and jump together.
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 5'd9, 1'b1, 5'd8, 1'b1, 1'b1, 1'b0);
      #2;
      chk("br_ctl1", {22'd0, c1}, {22'd0, E_BRANCH});
      chk("br_ctl3", {22'd0, c3}, {22'd0, E_BRANCH});
      tick();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b1, 1'b0);
      #2;
      chk("jump_ctl", {22'd0, c1}, {22'd0, E_JUMP});
      tick();
      chk("br_count3", {16'd0, sc3}, 32'd0);

      // Taken branch inside a multi-bubble stall returns to RUN.
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      tick();
      chk("lu_br_count3", {16'd0, sc3}, 32'd1);

      // Reset asserted mid-stall clears everything at once.
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 5'd0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
      tick();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      nRST = 1'b0;
      #2;
      chk("midrst_count3", {16'd0, sc3}, 32'd0);
      chk("midrst_ctl3", {22'd0, c3}, 32'd0);
      tick();
      nRST = 1'b1;
      tick();
      chk("midrst_run3", {22'd0, c3}, {22'd0, E_NORMAL});
      chk("midrst_cnt3b", {16'd0, sc3}, 32'd0);

      // Halt pulse: sticky from the next cycle despite ihit.
      do_reset();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1);
      #2;
      chk("halt_same_cycle", {31'd0, en_pc1}, 32'd1);
      tick();
      set_in(1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      #2;
      chk("halted1", {31'd0, halted1}, 32'd1);
      chk("halt_ctl", {22'd0, c1}, 32'd0);
      repeat (3) tick();
      chk("halt_hold", {31'd0, halted3}, 32'd1);
      chk("halt_count", {16'd0, sc1}, 32'd0);

      // Long freeze drives the stall counter into saturation.
      do_reset();
      set_in(1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0);
      repeat (65534) tick();
      chk("sat_pre", {16'd0, sc1}, 32'h0000FFFE);
      tick();
      chk("sat_hit", {16'd0, sc1}, 32'h0000FFFF);
      repeat (5) tick();
      chk("sat_hold1", {16'd0, sc1}, 32'h0000FFFF);
      chk("sat_hold3", {16'd0, sc3}, 32'h0000FFFF);
      chk("sat_model_pin", m_cnt[0], 32'd65535);

      @(negedge CLK);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised pipeline hazard controller for the 5-stage MIPS datapath (IF/ID/EX/MEM/WB); successor to the fixed enable/flush hazard block.
- Adds: memory-wait freeze, load-use interlock with configurable bubble count, taken-branch/jump squash, sticky halt, saturating stall-cycle counter.
- Drives the PC enable/redirect and the enable/flush pins of all four pipeline latches.

Parameters:
- REG_W, 5, register-address width.
- LU_BUBBLES, 1, bubbles inserted per load-use hazard (1..3).
- STALL_CNT_W, 16, stall counter width.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction fetch complete this cycle.
- dhit  in  1  data access complete this cycle.
- mem_dREN  in  1  MEM-stage load request.
- mem_dWEN  in  1  MEM-stage store request.
- id_rs  in  REG_W  ID-stage source register.
- id_rt  in  REG_W  ID-stage second source register.
- ex_memtoreg  in  1  EX-stage instruction is a load.
- ex_wsel  in  REG_W  EX-stage destination register.
- ex_branch_taken  in  1  branch resolved taken in EX.
- id_jump  in  1  J/JAL/JR decoded in ID.
- wb_halt  in  1  HALT reached WB.
- enable_pc  out  1  PC load enable.
- pc_redirect  out  1  select branch/jump target (vs PC+4).
- enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB  out  1 each  latch enables.
- flush_IF_ID, flush_ID_EX, flush_EX_MEM, flush_MEM_WB  out  1 each  latch clears (valid only with matching enable).
- halted  out  1  sticky halt indicator.
- stall_count  out  STALL_CNT_W  saturating count of stall cycles.

Behaviour:
- Reset (nRST=0, async): state RUN, bubble counter 0, halted 0, stall_count 0; all outputs 0.
- dreq = mem_dREN|mem_dWEN. advance = ihit & (~dreq | dhit).
- lu_hazard = ex_memtoreg & (ex_wsel!=0) & (ex_wsel==id_rs | ex_wsel==id_rt).
- FSM states: RUN, LU_STALL, HALT.
- RUN, advance=1, priority order:
  1. ex_branch_taken: pc_redirect=1; all enables 1; flush_IF_ID=1, flush_ID_EX=1. Overrides lu_hazard and id_jump.
  2. lu_hazard: enable_pc=0, enable_IF_ID=0, enable_ID_EX=1 with flush_ID_EX=1, EX_MEM/MEM_WB enabled. Counter loads LU_BUBBLES-1; if nonzero, go to LU_STALL.
  3. id_jump: pc_redirect=1; all enables 1; flush_IF_ID=1.
  4. otherwise: all enables 1, no flushes, pc_redirect=0.
- RUN, dreq & dhit & ~ihit: enable_EX_MEM=1, flush_EX_MEM=1, enable_MEM_WB=1; PC/IF_ID/ID_EX held. Completed access retires; request is not reissued.
- RUN, no advance and no dhit: all enables 0 (full freeze).
- LU_STALL: each advance cycle repeats the lu_hazard outputs and decrements the counter. Counter 0 after decrement -> RUN. Freeze rules apply while not advancing. ex_branch_taken in LU_STALL applies rule 1 and returns to RUN.
- HALT: entered on wb_halt from any state, registered. halted=1, all enables and flushes 0, pc_redirect 0. Left only by reset.
- stall_count: increments each cycle enable_pc=0 & ~halted. Saturates at all-ones, no wrap.
- Outputs are combinational from state + inputs. State, counter, halted and stall_count are registered.
- Reset asserted mid-stall: immediate return to RUN with counters cleared.

Test Plan:
- Reset, then ihit=1, no hazards, 10 cycles -> all enables 1, flushes 0, stall_count=0.
- ex_memtoreg=1, ex_wsel=8, id_rs=8, ihit=1 -> one cycle enable_pc=0, enable_IF_ID=0, flush_ID_EX=1; stall_count=1. Repeat with ex_wsel=0 -> no stall.
- LU_BUBBLES=3 build, same hazard -> exactly 3 bubble cycles, then RUN; stall_count=3.
- mem_dREN=1, ihit=0 for 4 cycles, then dhit=1 -> 4 frozen cycles, then flush_EX_MEM=1 with enable_MEM_WB=1; stall_count=5.
- ex_branch_taken=1 together with lu_hazard and id_jump -> pc_redirect=1, flush_IF_ID=flush_ID_EX=1, enable_pc=1, no stall.
- wb_halt pulse -> halted=1 from the next cycle with all enables 0, held despite ihit. Force stall_count near max -> saturates at 16'hFFFF.
